// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared defaults, feeder state encoding and flush-length
//                helper for the systolic array edge feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // Default operand width and array dimension
    localparam int c_default_data_w = 8;
    localparam int c_default_n      = 4;

    // Feeder FSM encoding; explicit values keep the encoding stable
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_t;

    // Zero cycles needed after the last beat for the skewed wavefront to
    // fully traverse an n x n array
    function automatic int flush_len(input int n);
        return (2 * n) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/skew_line.sv
`default_nettype none
// ============================================================================
//  Module      : skew_line
//  Description : DEPTH-stage shift register with asynchronous active-low
//                reset. A zero-select forces a zero word into the first
//                stage so bubbles and flush cycles push empty slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_zero,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_stage [DEPTH];

    // Shift the line by one stage per cycle; stage 0 takes data or zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_zero ? '0 : i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_skew_feeder
//  Description : West/north edge feeder for an N x N systolic MAC array.
//                Accepts one K-step (A column + B row) per beat, delays
//                lane k by k extra cycles, frames each tile with an
//                accumulator clear, a zero flush and a done pulse.
//  Options     : FEEDER_BEAT_CNT_EN - adds o_beat_cnt, beats accepted in
//                the current tile (saturating 16-bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N      = c_default_n,
    parameter int DATA_W = c_default_data_w
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [N*DATA_W-1:0] s_a,
    input  logic [N*DATA_W-1:0] s_b,
    input  logic                s_last,
    output logic [N*DATA_W-1:0] o_a,
    output logic [N*DATA_W-1:0] o_b,
    output logic                o_acc_clr_n,
    output logic                o_busy,
    output logic                o_done
`ifdef FEEDER_BEAT_CNT_EN
    ,
    output logic [15:0]         o_beat_cnt
`endif
);

    // Counter must hold 2N-1
    localparam int c_cnt_w = $clog2(2 * N);

    feeder_state_t        r_state;
    logic [c_cnt_w-1:0]   r_flush_cnt;
    logic                 r_done;
    logic                 w_accept;
    logic                 w_zero;

    // Handshake and framing strobes decode straight from the state register
    assign s_ready     = (r_state == ST_STREAM);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_acc_clr_n = (r_state != ST_CLEAR);
    assign w_accept    = s_valid && s_ready;
    // Anything other than an accepted beat injects a zero bubble on all lanes
    assign w_zero      = !w_accept;
    assign o_done      = r_done;

    // Tile framing FSM with flush countdown
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_valid) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_accept && s_last) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= c_cnt_w'(flush_len(N));
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == c_cnt_w'(1)) begin
                        r_state     <= ST_DONE;
                        r_flush_cnt <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - c_cnt_w'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_flush_cnt <= '0;
                end
            endcase
        end
    end

    // Done is registered so it lines up with the cycle spent in DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FLUSH) && (r_flush_cnt == c_cnt_w'(1));
        end
    end

`ifdef FEEDER_BEAT_CNT_EN
    logic [15:0] r_beat_cnt;

    // Beats accepted in the current tile; held after the tile until CLEAR
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_beat_cnt <= '0;
        end else if (w_accept && (r_beat_cnt != 16'hFFFF)) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    assign o_beat_cnt = r_beat_cnt;
`endif

    // Lane k of each operand is a (k+1)-deep line; A and B share depth
    for (genvar k = 0; k < N; k++) begin : g_lane
        skew_line #(
            .DEPTH  (k + 1),
            .DATA_W (DATA_W)
        ) u_skew_a (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_data  (s_a[k*DATA_W +: DATA_W]),
            .i_zero  (w_zero),
            .o_data  (o_a[k*DATA_W +: DATA_W])
        );

        skew_line #(
            .DEPTH  (k + 1),
            .DATA_W (DATA_W)
        ) u_skew_b (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_data  (s_b[k*DATA_W +: DATA_W]),
            .i_zero  (w_zero),
            .o_data  (o_b[k*DATA_W +: DATA_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_skew_feeder
//  Description : Scoreboard bench for systolic_skew_feeder. A reference
//                model tracks tile phase from the timing rules and records
//                the word entering the skew each cycle; the monitor expects
//                lane k to show the word entered k cycles earlier.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

    localparam int N = 4;
    localparam int W = 8;

    localparam int P_IDLE   = 0;
    localparam int P_CLEAR  = 1;
    localparam int P_STREAM = 2;
    localparam int P_FLUSH  = 3;
    localparam int P_DONE   = 4;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_last  = 1'b0;
    logic [N*W-1:0] s_a     = '0;
    logic [N*W-1:0] s_b     = '0;
    logic           s_ready;
    logic [N*W-1:0] o_a;
    logic [N*W-1:0] o_b;
    logic           o_acc_clr_n;
    logic           o_busy;
    logic           o_done;
`ifdef FEEDER_BEAT_CNT_EN
    logic [15:0]    o_beat_cnt;
`endif

    systolic_skew_feeder #(.N(N), .DATA_W(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_a         (s_a),
        .s_b         (s_b),
        .s_last      (s_last),
        .o_a         (o_a),
        .o_b         (o_b),
        .o_acc_clr_n (o_acc_clr_n),
        .o_busy      (o_busy),
        .o_done      (o_done)
`ifdef FEEDER_BEAT_CNT_EN
        ,
        .o_beat_cnt  (o_beat_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    // Bookkeeping
    int n_checks = 0;
    int n_errors = 0;
    bit in_rst   = 1'b1;

    // Reference model state
    int             m_phase     = P_IDLE;
    int             edge_cnt    = 0;
    int             m_done_edge = 0;
    bit             m_acc_evt   = 1'b0;
    int             m_beats     = 0;
    bit             mdl_acc;
    int             n_push      = 0;
    int             n_chk       = 0;
    logic [N*W-1:0] hist_a [$];
    logic [N*W-1:0] hist_b [$];
    int             done_q [$];

    // Monitor scratch
    bit             exp_done;
    logic [N*W-1:0] wa;
    logic [N*W-1:0] wb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: advance tile phase and record the word entering the skew
    initial forever begin
        @(posedge clk);
        if (rst_n) begin
            edge_cnt++;
            mdl_acc = (m_phase == P_STREAM) && s_valid;
            hist_a.push_back(mdl_acc ? s_a : '0);
            hist_b.push_back(mdl_acc ? s_b : '0);
            n_push++;
            m_acc_evt = mdl_acc;
            if (m_phase == P_CLEAR) m_beats = 0;
            if (mdl_acc && m_beats < 65535) m_beats++;
            case (m_phase)
                P_IDLE:   if (s_valid) m_phase = P_CLEAR;
                P_CLEAR:  m_phase = P_STREAM;
                P_STREAM: if (mdl_acc && s_last) begin
                    m_done_edge = edge_cnt + 2*N - 1;
                    done_q.push_back(m_done_edge);
                    m_phase = P_FLUSH;
                end
                P_FLUSH:  if (edge_cnt == m_done_edge) m_phase = P_DONE;
                default:  m_phase = P_IDLE;
            endcase
        end
    end

    // Monitor: compare DUT outputs against model and scoreboard each cycle
    initial forever begin
        @(negedge clk);
        #1;
        if (!in_rst) begin
            check("s_ready", 32'(s_ready), 32'(m_phase == P_STREAM));
            check("o_busy", 32'(o_busy), 32'(m_phase != P_IDLE));
            check("o_acc_clr_n", 32'(o_acc_clr_n), 32'(m_phase != P_CLEAR));
            exp_done = (done_q.size() > 0) && (done_q[0] == edge_cnt);
            check("o_done", 32'(o_done), 32'(exp_done));
            if (exp_done) void'(done_q.pop_front());
`ifdef FEEDER_BEAT_CNT_EN
            check("o_beat_cnt", 32'(o_beat_cnt), 32'(m_beats));
`endif
            if (n_push != n_chk) begin
                for (int k = 0; k < N; k++) begin
                    wa = hist_a[hist_a.size() - 1 - k];
                    wb = hist_b[hist_b.size() - 1 - k];
                    check($sformatf("o_a lane%0d", k), 32'(o_a[k*W +: W]), 32'(wa[k*W +: W]));
                    check($sformatf("o_b lane%0d", k), 32'(o_b[k*W +: W]), 32'(wb[k*W +: W]));
                end
                n_chk = n_push;
                while (hist_a.size() > N) void'(hist_a.pop_front());
                while (hist_b.size() > N) void'(hist_b.pop_front());
            end
        end
    end

    // Asynchronous reset mid-cycle; outputs must clear without an edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        in_rst = 1'b1;
        #1;
        check("rst o_a", 32'(o_a), 32'h0);
        check("rst o_b", 32'(o_b), 32'h0);
        check("rst o_acc_clr_n", 32'(o_acc_clr_n), 32'h1);
        check("rst o_busy", 32'(o_busy), 32'h0);
        check("rst o_done", 32'(o_done), 32'h0);
        check("rst s_ready", 32'(s_ready), 32'h0);
`ifdef FEEDER_BEAT_CNT_EN
        check("rst o_beat_cnt", 32'(o_beat_cnt), 32'h0);
`endif
        m_phase   = P_IDLE;
        m_beats   = 0;
        m_acc_evt = 1'b0;
        done_q.delete();
        hist_a.delete();
        hist_b.delete();
        for (int k = 0; k < N; k++) begin
            hist_a.push_back('0);
            hist_b.push_back('0);
        end
        n_chk   = n_push;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        in_rst = 1'b0;
    endtask

    // Present one beat and hold it until the model sees it accepted
    task automatic send_beat(input logic [N*W-1:0] a, input logic [N*W-1:0] b, input bit last);
        int n;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_last  = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_acc_evt && n < 16);
        if (!m_acc_evt) check("accept_timeout", 32'h0, 32'h1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic bubble();
        s_valid = 1'b0;
        s_a     = $urandom;
        s_b     = $urandom;
        @(negedge clk);
    endtask

    // After the last beat: junk on the bus (must be ignored), then wait
    // for the tile to close or cut it short with a reset
    task automatic finish_tile(input bit reset_mid);
        int n;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_last  = 1'($urandom_range(0, 1));
            s_a     = $urandom;
            s_b     = $urandom;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (reset_mid) begin
            do_reset();
            for (int i = 0; i < 2*N + 4; i++) @(negedge clk);
        end else begin
            n = 0;
            while (m_phase != P_IDLE && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (m_phase != P_IDLE) check("idle_timeout", 32'h0, 32'h1);
        end
    endtask

    function automatic logic [N*W-1:0] ramp(input int base);
        logic [N*W-1:0] w;
        for (int k = 0; k < N; k++) w[k*W +: W] = W'(base + k);
        return w;
    endfunction

    // Reference tile: lanes {1,2,3,4},{5..8},{9..12},{13..16}
    task automatic ref_tile(input bit with_bubble, input bit reset_mid);
        for (int i = 0; i < 4; i++) begin
            send_beat(ramp(1 + 4*i), ramp(101 + 4*i), i == 3);
            if (with_bubble && i == 1) bubble();
        end
        finish_tile(reset_mid);
    endtask

    initial begin
        logic [N*W-1:0] sa;
        logic [N*W-1:0] sb;
        int len;
        do_reset();
        @(negedge clk);

        ref_tile(1'b0, 1'b0);
        ref_tile(1'b1, 1'b0);

        // Signed extremes pass through bit-exact
        for (int k = 0; k < N; k++) begin
            sa[k*W +: W] = (k % 2 == 0) ? 8'h80 : 8'h7F;
            sb[k*W +: W] = (k % 2 == 0) ? 8'h7F : 8'h80;
        end
        send_beat(sa, sb, 1'b0);
        send_beat(sb, sa, 1'b1);
        finish_tile(1'b0);

        // Reset during FLUSH, then a clean tile
        ref_tile(1'b0, 1'b1);
        ref_tile(1'b0, 1'b0);

        // Randomized tiles: length, data, bubbles, idle gaps
        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(1, 6);
            for (int g = $urandom_range(0, 3); g > 0; g--) @(negedge clk);
            for (int i = 0; i < len; i++) begin
                send_beat($urandom, $urandom, i == len - 1);
                if (i != len - 1 && $urandom_range(0, 2) == 0) bubble();
            end
            finish_tile(1'b0);
        end

        for (int i = 0; i < 4; i++) @(negedge clk);
        check("done_q_empty", 32'(done_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
